// File: rtl/intr_pc_unit_pkg.sv
// Shared constants and field helpers for the jacaranda PC / interrupt unit.
// Stack entries are packed as {addr[PC_W], flag, lvl}.
package intr_pc_unit_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int NCH_DEF   = 4;
  localparam int DEPTH_DEF = 4;

  function automatic int lvl_w(input int nch);
    return $clog2(nch + 1);
  endfunction

  function automatic int idle_lvl(input int nch);
    return nch;
  endfunction

  function automatic int ent_w(input int pc_w, input int nch);
    return pc_w + 1 + lvl_w(nch);
  endfunction

endpackage

// File: rtl/intr_pc_unit_if.sv
// Control, interrupt and PC signals between the core and intr_pc_unit.
// master drives the controller side, slave is the unit itself.
interface intr_pc_unit_if
  import intr_pc_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int NCH  = NCH_DEF
);
  localparam int LW = lvl_w(NCH);

  logic                 jmp_en;
  logic                 je_en;
  logic                 ret;
  logic                 flag_w_en;
  logic                 alu_flag;
  logic [PC_W-1:0]      target;
  logic [NCH-1:0]       int_req;
  logic [NCH-1:0]       int_en;
  logic                 gie;
  logic [NCH*PC_W-1:0]  int_vec;
  logic [PC_W-1:0]      pc;
  logic                 flag;
  logic                 in_isr;
  logic [NCH-1:0]       int_ack;
  logic [LW-1:0]        cur_lvl;
  logic                 stack_err;

  modport master (
    output jmp_en, je_en, ret, flag_w_en,
    output alu_flag, target,
    output int_req, int_en, gie, int_vec,
    input  pc, flag, in_isr, int_ack,
    input  cur_lvl, stack_err
  );

  modport slave (
    input  jmp_en, je_en, ret, flag_w_en,
    input  alu_flag, target,
    input  int_req, int_en, gie, int_vec,
    output pc, flag, in_isr, int_ack,
    output cur_lvl, stack_err
  );

endinterface

// File: rtl/intr_pc_unit_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Index is returned at level width so it compares directly with cur_lvl.
module prio_enc
  import intr_pc_unit_pkg::*;
#(
  parameter int NCH = NCH_DEF
) (
  input  logic [NCH-1:0]          i_req,
  output logic                    o_vld,
  output logic [lvl_w(NCH)-1:0]   o_idx
);
  localparam int LW = lvl_w(NCH);

  always_comb begin
    o_vld = |i_req;
    o_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = LW'(i);
    end
  end

endmodule

// File: rtl/intr_pc_unit.sv
// PC sequencer with prioritised interrupts and a return stack.
// INTR_NEST_EN enables nesting/preemption up to DEPTH levels.
module intr_pc_unit
  import intr_pc_unit_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clock,
  input  logic          reset,
  intr_pc_unit_if.slave bus
);
  localparam int LW = lvl_w(NCH);
  localparam int EW = ent_w(PC_W, NCH);
`ifdef INTR_NEST_EN
  localparam int SD = DEPTH;
`else
  localparam int SD = 1;
`endif
  localparam int DW = $clog2(SD + 1);
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [LW-1:0] IDLE = LW'(idle_lvl(NCH));

  logic [PC_W-1:0] r_pc;
  logic            r_flag;
  logic [LW-1:0]   r_lvl;
  logic [DW-1:0]   r_depth;
  logic [NCH-1:0]  r_pend;
  logic [NCH-1:0]  r_req_q;
  logic            r_err;
  logic [EW-1:0]   r_stk [SD];

  logic            w_vld;
  logic [LW-1:0]   w_idx;
  logic            w_take;
  logic            w_pop;
  logic [AW-1:0]   w_top_a;
  logic [EW-1:0]   w_top;
  logic [PC_W-1:0] w_inc;
  logic [PC_W-1:0] w_pc_n;
  logic            w_flag_n;
  logic [LW-1:0]   w_lvl_n;
  logic [NCH-1:0]  w_ack;
  logic [NCH-1:0]  w_pend_n;
  logic [PC_W-1:0] w_vec;

  prio_enc #(.NCH(NCH)) u_enc (
    .i_req (r_pend & bus.int_en),
    .o_vld (w_vld),
    .o_idx (w_idx)
  );

  always_comb begin
    w_top_a  = (r_depth == '0) ? '0 : AW'(r_depth - DW'(1));
    w_top    = r_stk[w_top_a];
    w_pop    = bus.ret && (r_depth != '0);
    w_inc    = r_pc + PC_W'(1);
    w_pc_n   = w_inc;
    w_flag_n = r_flag;
    w_lvl_n  = r_lvl;
    if (bus.ret) begin
      if (w_pop) {w_pc_n, w_flag_n, w_lvl_n} = w_top;
    end else if (bus.jmp_en) begin
      w_pc_n = bus.target;
    end else if (bus.je_en) begin
      w_pc_n = r_flag ? bus.target : w_inc;
    end
    if (!bus.ret && bus.je_en) w_flag_n = 1'b0;
    else if (!bus.ret && bus.flag_w_en) w_flag_n = bus.alu_flag;

    // Single-level build: SD=1, so the depth test also enforces !in_isr.
    w_take = w_vld && bus.gie && !bus.ret &&
             (w_idx < r_lvl) && (r_depth < DW'(SD));
    w_ack  = w_take ? (NCH'(1) << w_idx) : '0;
    w_vec  = bus.int_vec[int'(w_idx)*PC_W +: PC_W];
    // A fresh edge on the acked channel re-arms it.
    w_pend_n = (r_pend & ~w_ack) | (bus.int_req & ~r_req_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc    <= '0;
      r_flag  <= 1'b0;
      r_lvl   <= IDLE;
      r_depth <= '0;
      r_pend  <= '0;
      r_req_q <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < SD; i++) r_stk[i] <= '0;
    end else begin
      r_req_q <= bus.int_req;
      r_pend  <= w_pend_n;
      if (bus.ret && r_depth == '0) r_err <= 1'b1;
      if (w_take) begin
        r_stk[AW'(r_depth)] <= {w_pc_n, w_flag_n, r_lvl};
        r_pc    <= w_vec;
        r_flag  <= w_flag_n;
        r_lvl   <= w_idx;
        r_depth <= r_depth + DW'(1);
      end else begin
        r_pc   <= w_pc_n;
        r_flag <= w_flag_n;
        r_lvl  <= w_lvl_n;
        if (w_pop) r_depth <= r_depth - DW'(1);
      end
    end
  end

  assign bus.pc        = r_pc;
  assign bus.flag      = r_flag;
  assign bus.in_isr    = (r_depth != '0);
  assign bus.int_ack   = w_ack;
  assign bus.cur_lvl   = r_lvl;
  assign bus.stack_err = r_err;

endmodule

// File: tb/tb_intr_pc_unit.sv
// Scoreboard bench for intr_pc_unit: per-cycle expected outputs are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_intr_pc_unit;

  logic clock;
  logic reset;

  intr_pc_unit_if #(.PC_W(8), .NCH(4)) bus ();

`ifdef INTR_NEST_EN
  localparam int TB_DEPTH = 2;
`else
  localparam int TB_DEPTH = 4;
`endif

  intr_pc_unit #(.PC_W(8), .NCH(4), .DEPTH(TB_DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string nm;
    int    pc;
    int    flag;
    int    isr;
    int    ack;
    int    lvl;
    int    err;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic ex(input string nm, input int pc, input int fl,
                    input int isr, input int ack, input int lvl,
                    input int err);
    exp_t r;
    r.nm = nm; r.pc = pc; r.flag = fl; r.isr = isr;
    r.ack = ack; r.lvl = lvl; r.err = err;
    q.push_back(r);
  endtask

  task automatic chk(input string nm, input string fld,
                     input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h, want %0h", nm, fld, act, req);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "pc",   int'(bus.pc),        e.pc);
        chk(e.nm, "flag", int'(bus.flag),      e.flag);
        chk(e.nm, "isr",  int'(bus.in_isr),    e.isr);
        chk(e.nm, "ack",  int'(bus.int_ack),   e.ack);
        chk(e.nm, "lvl",  int'(bus.cur_lvl),   e.lvl);
        chk(e.nm, "err",  int'(bus.stack_err), e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.jmp_en    = 1'b0;
    bus.je_en     = 1'b0;
    bus.ret       = 1'b0;
    bus.flag_w_en = 1'b0;
    bus.alu_flag  = 1'b0;
    bus.target    = '0;
    bus.int_req   = '0;
    bus.int_en    = '0;
    bus.gie       = 1'b0;
    bus.int_vec   = {8'hE0, 8'hC0, 8'h80, 8'hA0};

    nxt(); ex("rst", 0, 0, 0, 0, 4, 0);
    reset = 1'b0;

    for (int k = 1; k <= 300; k++) begin
      nxt(); ex("lin", k % 256, 0, 0, 0, 4, 0);
    end

    bus.jmp_en = 1'b1; bus.target = 8'h0F;
    bus.int_en = 4'b0010; bus.gie = 1'b1;
    nxt(); bus.jmp_en = 1'b0; bus.int_req = 4'b0010;
    bus.flag_w_en = 1'b1; bus.alu_flag = 1'b1;
    ex("c1_pre", 8'h0F, 0, 0, 0, 4, 0);
    nxt(); bus.flag_w_en = 1'b0;
    ex("c1_take", 8'h10, 1, 0, 4'b0010, 4, 0);
    nxt(); bus.flag_w_en = 1'b1; bus.alu_flag = 1'b0;
    ex("c1_isr", 8'h80, 1, 1, 0, 1, 0);
    nxt(); bus.flag_w_en = 1'b0; bus.ret = 1'b1;
    ex("c1_isr2", 8'h81, 0, 1, 0, 1, 0);
    nxt(); bus.ret = 1'b0; bus.int_req = '0;
    ex("c1_ret", 8'h11, 1, 0, 0, 4, 0);

    nxt(); bus.int_en = 4'b0001; bus.int_req = 4'b0001;
    ex("je_pre", 8'h12, 1, 0, 0, 4, 0);
    nxt(); bus.je_en = 1'b1; bus.target = 8'h40;
    ex("je_take", 8'h13, 1, 0, 4'b0001, 4, 0);
    nxt(); bus.je_en = 1'b0; bus.flag_w_en = 1'b1; bus.alu_flag = 1'b1;
    ex("je_isr", 8'hA0, 0, 1, 0, 0, 0);
    nxt(); bus.flag_w_en = 1'b0; bus.ret = 1'b1;
    ex("je_isr2", 8'hA1, 1, 1, 0, 0, 0);
    nxt(); bus.ret = 1'b0; bus.int_req = '0;
    ex("je_ret", 8'h40, 0, 0, 0, 4, 0);

`ifdef INTR_NEST_EN
    nxt(); bus.int_en = 4'b1101; bus.int_req = 4'b0100;
    ex("n_pre", 8'h41, 0, 0, 0, 4, 0);
    nxt(); ex("n_c2", 8'h42, 0, 0, 4'b0100, 4, 0);
    nxt(); bus.int_req = 4'b0101;
    ex("n_in2", 8'hC0, 0, 1, 0, 2, 0);
    nxt(); ex("n_pre0", 8'hC1, 0, 1, 4'b0001, 2, 0);
    nxt(); bus.int_req = 4'b1101;
    ex("n_in0", 8'hA0, 0, 1, 0, 0, 0);
    nxt(); ex("n_hold3", 8'hA1, 0, 1, 0, 0, 0);
    nxt(); bus.ret = 1'b1;
    ex("n_ret0", 8'hA2, 0, 1, 0, 0, 0);
    nxt(); bus.ret = 1'b0;
    ex("n_back2", 8'hC2, 0, 1, 0, 2, 0);
    nxt(); bus.ret = 1'b1;
    ex("n_ret2", 8'hC3, 0, 1, 0, 2, 0);
    nxt(); bus.ret = 1'b0;
    ex("n_c3", 8'h43, 0, 0, 4'b1000, 4, 0);
    nxt(); bus.int_en = 4'b1111; bus.int_req = 4'b1111;
    ex("n_in3", 8'hE0, 0, 1, 0, 3, 0);
    nxt(); ex("n_c1", 8'hE1, 0, 1, 4'b0010, 3, 0);
    nxt(); bus.int_req = 4'b1110;
    ex("n_in1", 8'h80, 0, 1, 0, 1, 0);
    nxt(); bus.int_req = 4'b1111;
    ex("n_in1b", 8'h81, 0, 1, 0, 1, 0);
    nxt(); ex("n_full", 8'h82, 0, 1, 0, 1, 0);
    nxt(); bus.ret = 1'b1;
    ex("n_fret", 8'h83, 0, 1, 0, 1, 0);
    nxt(); bus.ret = 1'b0;
    ex("n_c0", 8'hE2, 0, 1, 4'b0001, 3, 0);
    nxt(); bus.int_req = '0;
    ex("n_in0b", 8'hA0, 0, 1, 0, 0, 0);
    nxt(); ex("n_in0c", 8'hA1, 0, 1, 0, 0, 0);
`else
    nxt(); bus.int_en = 4'b0101; bus.int_req = 4'b0100;
    ex("s_pre", 8'h41, 0, 0, 0, 4, 0);
    nxt(); ex("s_c2", 8'h42, 0, 0, 4'b0100, 4, 0);
    nxt(); bus.int_req = 4'b0101;
    ex("s_in2", 8'hC0, 0, 1, 0, 2, 0);
    nxt(); ex("s_hold0", 8'hC1, 0, 1, 0, 2, 0);
    nxt(); bus.ret = 1'b1;
    ex("s_ret2", 8'hC2, 0, 1, 0, 2, 0);
    nxt(); bus.ret = 1'b0;
    ex("s_c0", 8'h43, 0, 0, 4'b0001, 4, 0);
    nxt(); bus.int_req = '0;
    ex("s_in0", 8'hA0, 0, 1, 0, 0, 0);
    nxt(); ex("s_in0b", 8'hA1, 0, 1, 0, 0, 0);
`endif

    nxt(); reset = 1'b1;
    ex("rst_isr", 0, 0, 0, 0, 4, 0);
    nxt(); reset = 1'b0; bus.jmp_en = 1'b1; bus.target = 8'h05;
    ex("rst_hold", 0, 0, 0, 0, 4, 0);
    nxt(); bus.jmp_en = 1'b0; bus.ret = 1'b1;
    ex("e_pre", 8'h05, 0, 0, 0, 4, 0);
    nxt(); bus.ret = 1'b0;
    ex("e_err", 8'h06, 0, 0, 0, 4, 1);
    nxt(); bus.int_en = 4'b0001; bus.int_req = 4'b0001;
    ex("e_sticky", 8'h07, 0, 0, 0, 4, 1);
    nxt(); ex("e_take", 8'h08, 0, 0, 4'b0001, 4, 1);
    nxt(); ex("e_isr", 8'hA0, 0, 1, 0, 0, 1);
    nxt(); reset = 1'b1; bus.int_req = '0;
    ex("rst_mid", 0, 0, 0, 0, 4, 0);
    nxt(); reset = 1'b0; bus.gie = 1'b0;
    bus.int_en = 4'b0001; bus.int_req = 4'b0001;
    ex("g_rst", 0, 0, 0, 0, 4, 0);
    nxt(); ex("g_off", 1, 0, 0, 0, 4, 0);
    nxt(); bus.gie = 1'b1;
    ex("g_on", 2, 0, 0, 4'b0001, 4, 0);
    nxt(); ex("g_isr", 8'hA0, 0, 1, 0, 0, 0);

    repeat (4) @(negedge clock);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intr_pc_unit.md
Name: intr_pc_unit

Overview:
- Parametrised program-counter and interrupt sequencer for the next-generation jacaranda core.
- Replaces the single-request, single-level PC/ret_addr/flag logic with NCH masked, prioritised interrupt channels and a hardware return stack of return address, flag and priority level.
- Sits between main_controller (jmp_en/je_en/ret/flag_w_en), the ALU (flag source), the regfile (jump target) and the instruction fetch (pc).

Parameters:
- PC_W, 8, program counter and vector width.
- NCH, 4, number of interrupt channels; channel 0 has the highest priority.
- DEPTH, 4, return-stack entries (maximum nesting depth).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- jmp_en  in  1  unconditional jump this cycle.
- je_en  in  1  conditional jump on flag this cycle.
- ret  in  1  return-from-interrupt this cycle.
- flag_w_en  in  1  load flag from alu_flag.
- alu_flag  in  1  ALU result bit 0.
- target  in  PC_W  jump target (rs_data).
- int_req  in  NCH  level requests, one per channel.
- int_en  in  NCH  per-channel mask.
- gie  in  1  global interrupt enable.
- int_vec  in  NCH*PC_W  vectors; channel i at bits [i*PC_W +: PC_W].
- pc  out  PC_W  current program counter.
- flag  out  1  condition flag.
- in_isr  out  1  stack depth nonzero.
- int_ack  out  NCH  one-hot pulse on the cycle a channel is taken.
- cur_lvl  out  $clog2(NCH+1)  active priority level; NCH = idle.
- stack_err  out  1  sticky: ret with empty stack.

Behaviour:
- Reset values: pc=0, flag=0, depth=0, cur_lvl=NCH, pending=0, int_ack=0, stack_err=0, in_isr=0.
- Pending: pending[i] is set on a rising edge of int_req[i] (registered edge detect). It is cleared on ack. If set and clear coincide, set wins.
- Normal next state, computed every cycle in this priority order:
  - ret: pc=popped addr, flag=popped flag, cur_lvl=popped lvl.
  - jmp_en: pc=target.
  - je_en: pc = flag ? target : pc+1, and flag=0.
  - otherwise: pc=pc+1.
  - flag_w_en loads alu_flag when neither ret nor je_en is active.
  - pc+1 wraps modulo 2^PC_W.
- Eligible channel: lowest index i with pending[i] & int_en[i].
- Take condition, all of which must hold: eligible channel exists, gie=1, ret=0, i < cur_lvl, and depth < DEPTH.
- On take, in one cycle:
  - Push {normal next pc, normal next flag, cur_lvl}.
  - pc=int_vec[i]; flag=normal next flag.
  - cur_lvl=i; depth+1.
  - int_ack[i]=1 for exactly that cycle; pending[i] cleared.
  - The current instruction completes; only the PC is redirected.
- ret with depth=0:
  - pc=pc+1, flag and cur_lvl unchanged.
  - stack_err=1, cleared only by reset.
- ret and eligible interrupt in the same cycle: ret wins; the interrupt stays pending and is evaluated next cycle against the restored cur_lvl.
- Stack full (depth=DEPTH): no take; requests remain pending.
- Equal or lower priority than cur_lvl: held pending until cur_lvl rises.
- gie=0: pending still latches edges; nothing is taken.
- Reset mid-ISR: stack, pending and levels are discarded; pc=0.
- Every register uses posedge clock or posedge reset.

Optional Feature:
- Macro: INTR_NEST_EN.
- Defined: nesting and preemption as described above, with an effective stack depth of DEPTH.
- Undefined:
  - Effective depth is 1; the take condition additionally requires in_isr=0.
  - The priority level is used only for selection; the stack is a single register set.
  - A ret at depth 0 still sets stack_err.

Decomposition:
- Shared package/header:
  - IDLE_LVL = NCH constant.
  - Level width function $clog2(NCH+1).
  - Stack-entry field layout {addr[PC_W], flag, lvl}.
- One sub-module, prio_enc: NCH-bit masked request in, returns the valid bit and lowest set index.
- Stack storage and depth counter stay inline.

Test Plan:
- Straight-line code, no interrupts, 300 cycles with PC_W=8 → pc counts 0..255, wraps to 0; in_isr=0; int_ack=0.
- int_en=4'b0010, gie=1, rising edge on int_req[1] at pc=0x10 with no jump, int_vec[1]=0x80 → next pc=0x80, int_ack=4'b0010 for 1 cycle, cur_lvl=1. A later ret → pc=0x11, flag restored, cur_lvl=4.
- je_en with flag=1, target=0x40, and a channel-0 take in the same cycle → pushed addr=0x40, pushed flag=0; ret → pc=0x40, flag=0.
- Nested (INTR_NEST_EN) with channel 2 active:
  - Channel 0 edge → preempts, depth=2.
  - Channel 3 edge → stays pending.
  - Two rets → returns to the channel-2 then the main context; channel 3 is taken after cur_lvl returns to 4.
- DEPTH=2, channel 0 edge while at depth 2 → no take, int_ack=0; after one ret, channel 0 is taken next cycle. Without INTR_NEST_EN, any edge while in_isr=1 stays pending until ret.
- ret at depth 0 with pc=0x05 → pc=0x06, stack_err=1 stays set. reset asserted mid-ISR → pc=0, in_isr=0, stack_err=0 immediately.
